// File: rtl/feeder_pkg.sv
// Shared types and defaults for the serial operand feeder.
package feeder_pkg;

    // Default operand width in bits.
    localparam int unsigned DefaultWidth = 8;

    // Frame sequencer states: wait, clear pulse, operand bits, zero pad.
    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StShift,
        StFlush
    } feeder_state_e;

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out register: parallel load, shift right with zero fill.
// q0 always presents the bit that goes out next.
module piso_shift #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] d,
    output logic             q0
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority over shift; zero fill means the register drains to 0.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = d;
        end else if (shift) begin
            sr_d = {1'b0, sr_q[WIDTH-1:1]};
        end
    end

    // Shift register state with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign q0 = sr_q[0];

endmodule

// File: rtl/serial_operand_feeder.sv
// Serial operand feeder: accepts one parallel operand pair, pulses CLR, then
// streams both operands LSB-first followed by PAD zero cycles.
// Optional build macro FEEDER_SKID_EN adds a one-entry skid buffer so the next
// pair can be accepted while a frame runs (back-to-back frames, no idle gap).
module serial_operand_feeder
    import feeder_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned PAD   = WIDTH
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             CLR,
    output logic             A,
    output logic             B,
    output logic             FRAME,
    output logic             LAST
);

    localparam int unsigned Total = WIDTH + PAD;
    localparam int unsigned CW    = $clog2(WIDTH + PAD + 1);

    localparam logic [CW-1:0] CntLast  = CW'(Total - 1);
    localparam logic [CW-1:0] CntWidth = CW'(WIDTH);

    feeder_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clr_q, clr_d;
    logic          a_q, a_d;
    logic          b_q, b_d;
    logic          frame_q, frame_d;
    logic          last_q, last_d;

    logic             accept;
    logic             load;
    logic             shift;
    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic             sa_q0;
    logic             sb_q0;

`ifdef FEEDER_SKID_EN
    logic             skid_full_q, skid_full_d;
    logic [WIDTH-1:0] skid_a_q, skid_a_d;
    logic [WIDTH-1:0] skid_b_q, skid_b_d;
    logic             take_direct;

    // Ready whenever the skid slot is free, in any state.
    assign in_ready = !RST && !skid_full_q;
`else
    // Ready only while idle; one pair in flight at a time.
    assign in_ready = !RST && (state_q == StIdle);
`endif

    assign accept = in_valid && in_ready;

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso_a (
        .CLK   (CLK),
        .RST   (RST),
        .load  (load),
        .shift (shift),
        .d     (load_a),
        .q0    (sa_q0)
    );

    piso_shift #(
        .WIDTH (WIDTH)
    ) u_piso_b (
        .CLK   (CLK),
        .RST   (RST),
        .load  (load),
        .shift (shift),
        .d     (load_b),
        .q0    (sb_q0)
    );

    // Next-state and next-output logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        clr_d   = 1'b0;
        a_d     = 1'b0;
        b_d     = 1'b0;
        frame_d = 1'b0;
        last_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        load_a  = in_a;
        load_b  = in_b;
`ifdef FEEDER_SKID_EN
        take_direct = 1'b0;
        skid_full_d = skid_full_q;
        skid_a_d    = skid_a_q;
        skid_b_d    = skid_b_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    load    = 1'b1;
                    clr_d   = 1'b1;
                    state_d = StLoad;
`ifdef FEEDER_SKID_EN
                    take_direct = 1'b1;
`endif
                end
            end

            // CLR cycle; the next edge emits bit 0 and starts the count.
            StLoad: begin
                state_d = StShift;
                cnt_d   = '0;
                a_d     = sa_q0;
                b_d     = sb_q0;
                shift   = 1'b1;
                frame_d = 1'b1;
            end

            // cnt_q is the index of the bit currently on A/B.
            StShift, StFlush: begin
                if (cnt_q == CntLast) begin
`ifdef FEEDER_SKID_EN
                    if (skid_full_q) begin
                        load        = 1'b1;
                        load_a      = skid_a_q;
                        load_b      = skid_b_q;
                        skid_full_d = 1'b0;
                        clr_d       = 1'b1;
                        state_d     = StLoad;
                    end else if (accept) begin
                        // Pair arriving on the last cycle goes straight in.
                        take_direct = 1'b1;
                        load        = 1'b1;
                        clr_d       = 1'b1;
                        state_d     = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
`else
                    state_d = StIdle;
`endif
                end else begin
                    cnt_d   = cnt_q + CW'(1);
                    frame_d = 1'b1;
                    last_d  = (cnt_d == CntLast);
                    if (cnt_d < CntWidth) begin
                        state_d = StShift;
                        a_d     = sa_q0;
                        b_d     = sb_q0;
                        shift   = 1'b1;
                    end else begin
                        state_d = StFlush;
                    end
                end
            end

            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef FEEDER_SKID_EN
        // Any accept not consumed directly by the sequencer parks in the skid slot.
        if (accept && !take_direct) begin
            skid_full_d = 1'b1;
            skid_a_d    = in_a;
            skid_b_d    = in_b;
        end
`endif
    end

    // Sequencer state, counter and registered outputs.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            clr_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            frame_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            frame_q <= frame_d;
            last_q  <= last_d;
        end
    end

`ifdef FEEDER_SKID_EN
    // Skid buffer holding the next operand pair.
    always_ff @(posedge CLK) begin
        if (RST) begin
            skid_full_q <= 1'b0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
        end else begin
            skid_full_q <= skid_full_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
        end
    end
`endif

    assign CLR   = clr_q;
    assign A     = a_q;
    assign B     = b_q;
    assign FRAME = frame_q;
    assign LAST  = last_q;

endmodule

// File: tb/tb_serial_operand_feeder.sv
// Directed bench for serial_operand_feeder (WIDTH=8, PAD=8).
module tb_serial_operand_feeder;

    logic       CLK = 1'b0;
    logic       RST;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic       CLR;
    logic       A;
    logic       B;
    logic       FRAME;
    logic       LAST;

    int n_checks = 0;
    int n_fail   = 0;

    serial_operand_feeder #(
        .WIDTH (8),
        .PAD   (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .CLR      (CLR),
        .A        (A),
        .B        (B),
        .FRAME    (FRAME),
        .LAST     (LAST)
    );

    always #5 CLK = ~CLK;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Send one pair and record a whole frame; also runs a bit-serial multiplier model
    // (cleared by CLR) on the A/B stream so the product bits on O can be compared.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b,
                             output logic [15:0] sa, output logic [15:0] sb,
                             output logic [15:0] prod, output logic [2:0] flags,
                             output logic timed_out);
        logic [15:0] acc;
        logic [15:0] as_seen;
        logic [15:0] bs_seen;
        logic [15:0] as_excl;
        logic        clr_ok;
        logic        frame_ok;
        logic        last_ok;
        int          k;
        sa = '0; sb = '0; prod = '0; acc = '0; as_seen = '0; bs_seen = '0;
        clr_ok = 1'b0; frame_ok = 1'b1; last_ok = 1'b1; timed_out = 1'b0;
        in_a = a; in_b = b; in_valid = 1'b1;
        k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        if (!in_ready) begin
            timed_out = 1'b1;
            in_valid  = 1'b0;
        end else begin
            tick();
            in_valid = 1'b0;
            in_a = ~a;
            in_b = ~b;
            clr_ok = CLR && !FRAME;
            if (CLR) begin
                acc = '0; as_seen = '0; bs_seen = '0;
            end
            for (int i = 0; i < 16; i++) begin
                tick();
                sa[i] = A;
                sb[i] = B;
                if (!FRAME || CLR) frame_ok = 1'b0;
                if (LAST !== (i == 15)) last_ok = 1'b0;
                as_excl = as_seen;
                if (B) bs_seen[i] = 1'b1;
                if (A) acc = acc + (bs_seen << i);
                if (B) acc = acc + (as_excl << i);
                if (A) as_seen[i] = 1'b1;
                prod[i] = acc[i];
            end
        end
        flags = {clr_ok, frame_ok, last_ok};
    endtask

    task automatic test_reset();
        RST = 1'b1; in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 0", in_ready);
        end
        n_checks++;
        if ({CLR, A, B, FRAME, LAST} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 00000", {CLR, A, B, FRAME, LAST});
        end
        RST = 1'b0; in_valid = 1'b0;
        tick();
        n_checks++;
        if ({in_ready, CLR} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b expected 10", {in_ready, CLR});
        end
        tick();
        n_checks++;
        if ({CLR, FRAME} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_nothing_captured: got %b expected 00", {CLR, FRAME});
        end
    endtask

    task automatic test_single_frame();
        logic [15:0] ea;
        logic [15:0] eb;
        logic [4:0]  exp_o;
        ea = 16'h00A5;
        eb = 16'h0003;
        in_valid = 1'b1; in_a = 8'hA5; in_b = 8'h03;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 1", in_ready);
        end
        tick();
        in_valid = 1'b0; in_a = 8'h5A; in_b = 8'hC3;
        n_checks++;
        if ({CLR, FRAME, A, B, LAST} !== 5'b10000) begin
            n_fail++;
            $display("FAIL single_clr: got %b expected 10000", {CLR, FRAME, A, B, LAST});
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            exp_o = {1'b0, 1'b1, ea[i], eb[i], (i == 15)};
            n_checks++;
            if ({CLR, FRAME, A, B, LAST} !== exp_o) begin
                n_fail++;
                $display("FAIL single_bit%0d {CLR,FRAME,A,B,LAST}: got %b expected %b",
                         i, {CLR, FRAME, A, B, LAST}, exp_o);
            end
        end
        tick();
        n_checks++;
        if ({FRAME, LAST, in_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL single_end: got %b expected 001", {FRAME, LAST, in_ready});
        end
    endtask

    task automatic test_end_to_end();
        logic [7:0]  va [4];
        logic [7:0]  vb [4];
        logic [15:0] vp [4];
        logic [15:0] sa, sb, prod;
        logic [2:0]  flags;
        logic        to;
        va[0] = 8'hFF; vb[0] = 8'hFF; vp[0] = 16'hFE01;
        va[1] = 8'h00; vb[1] = 8'h00; vp[1] = 16'h0000;
        va[2] = 8'h01; vb[2] = 8'h01; vp[2] = 16'h0001;
        va[3] = 8'h80; vb[3] = 8'h80; vp[3] = 16'h4000;
        for (int n = 0; n < 4; n++) begin
            run_frame(va[n], vb[n], sa, sb, prod, flags, to);
            n_checks++;
            if (to !== 1'b0) begin
                n_fail++;
                $display("FAIL e2e%0d_timeout: in_ready never rose", n);
            end
            n_checks++;
            if (prod !== vp[n]) begin
                n_fail++;
                $display("FAIL e2e%0d_product: got %h expected %h", n, prod, vp[n]);
            end
            n_checks++;
            if (sa !== {8'h00, va[n]}) begin
                n_fail++;
                $display("FAIL e2e%0d_serial_a: got %h expected %h", n, sa, {8'h00, va[n]});
            end
            n_checks++;
            if (sb !== {8'h00, vb[n]}) begin
                n_fail++;
                $display("FAIL e2e%0d_serial_b: got %h expected %h", n, sb, {8'h00, vb[n]});
            end
            n_checks++;
            if (flags !== 3'b111) begin
                n_fail++;
                $display("FAIL e2e%0d_clr_frame_last: got %b expected 111", n, flags);
            end
        end
        tick();
    endtask

`ifdef FEEDER_SKID_EN
    task automatic test_back_to_back();
        int busy;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({CLR, in_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_load_ready: got %b expected 11", {CLR, in_ready});
        end
        tick();
        tick();
        in_valid = 1'b1; in_a = 8'h33; in_b = 8'h44;
        tick();
        in_a = 8'h55; in_b = 8'h66;
        busy = (in_ready == 1'b0) ? 1 : 0;
        for (int i = 0; i < 13; i++) begin
            tick();
            if (in_ready == 1'b0) busy++;
        end
        n_checks++;
        if ({busy, LAST} !== {32'd14, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_skid_full: got busy=%0d last=%b expected busy=14 last=1",
                     busy, LAST);
        end
        tick();
        n_checks++;
        if ({CLR, FRAME, in_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL b2b_no_gap: got %b expected 101", {CLR, FRAME, in_ready});
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({FRAME, A, B} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_frame2_bit0: got %b expected 110", {FRAME, A, B});
        end
        for (int i = 0; i < 16; i++) tick();
        n_checks++;
        if ({CLR, FRAME} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_frame3_clr: got %b expected 10", {CLR, FRAME});
        end
        for (int i = 0; i < 18; i++) tick();
    endtask
`else
    task automatic test_back_to_back();
        int busy;
        in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first_ready: got %b expected 1", in_ready);
        end
        busy = 0;
        for (int i = 0; i < 17; i++) begin
            tick();
            if (in_ready == 1'b0) busy++;
        end
        n_checks++;
        if (busy !== 17) begin
            n_fail++;
            $display("FAIL b2b_busy_cycles: got %0d expected 17", busy);
        end
        tick();
        n_checks++;
        if ({in_ready, FRAME, CLR} !== 3'b100) begin
            n_fail++;
            $display("FAIL b2b_idle_gap: got %b expected 100", {in_ready, FRAME, CLR});
        end
        tick();
        in_valid = 1'b0;
        n_checks++;
        if ({CLR, in_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL b2b_frame2_clr: got %b expected 10", {CLR, in_ready});
        end
        tick();
        n_checks++;
        if ({FRAME, A, B} !== 3'b110) begin
            n_fail++;
            $display("FAIL b2b_frame2_bit0: got %b expected 110", {FRAME, A, B});
        end
        for (int i = 0; i < 15; i++) tick();
        n_checks++;
        if ({FRAME, LAST} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_frame2_last: got %b expected 11", {FRAME, LAST});
        end
        tick();
    endtask
`endif

    task automatic test_reset_mid_frame();
        logic [15:0] sa, sb, prod;
        logic [2:0]  flags;
        logic        to;
        in_valid = 1'b1; in_a = 8'hFF; in_b = 8'hFF;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if ({FRAME, A, B} !== 3'b111) begin
            n_fail++;
            $display("FAIL midrst_bit3: got %b expected 111", {FRAME, A, B});
        end
        RST = 1'b1;
        tick();
        n_checks++;
        if ({CLR, A, B, FRAME, LAST, in_ready} !== 6'b000000) begin
            n_fail++;
            $display("FAIL midrst_abort: got %b expected 000000",
                     {CLR, A, B, FRAME, LAST, in_ready});
        end
        RST = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({CLR, FRAME, A, B} !== 4'b0000) begin
            n_fail++;
            $display("FAIL midrst_quiet: got %b expected 0000", {CLR, FRAME, A, B});
        end
        run_frame(8'h01, 8'h01, sa, sb, prod, flags, to);
        n_checks++;
        if ({to, flags} !== 4'b0111) begin
            n_fail++;
            $display("FAIL midrst_clean_flags: got %b expected 0111", {to, flags});
        end
        n_checks++;
        if ({sa, sb, prod} !== {16'h0001, 16'h0001, 16'h0001}) begin
            n_fail++;
            $display("FAIL midrst_clean_data: got %h/%h/%h expected 0001/0001/0001",
                     sa, sb, prod);
        end
        tick();
    endtask

    initial begin
        RST = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
        test_reset();
        test_single_frame();
        test_end_to_end();
        test_back_to_back();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

endmodule
